// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - shared keycode widths and helpers for the keypad register FIFO
package teclado_pkg;

  localparam int ROW_W_DEF = 2;
  localparam int COL_W_DEF = 2;

  function automatic int key_width(input int row_w, input int col_w);
    return row_w + col_w;
  endfunction

  typedef logic [ROW_W_DEF+COL_W_DEF-1:0] keycode_t;

endpackage

// File: rtl/filtro_repeticion.sv
// rtl/filtro_repeticion.sv - last-key register plus holdoff counter, flags repeats of the same key
module filtro_repeticion #(
  parameter int KW      = 4,
  parameter int HOLDOFF = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [KW-1:0] key,
  input  logic          we,
  input  logic          accept,
  output logic          discard
);

  localparam int CW = $clog2(HOLDOFF + 1);

  logic [KW-1:0] last;
  logic [CW-1:0] holdoff;

  assign discard = we && (holdoff != '0) && (key == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= '0;
      holdoff <= '0;
    end else if (clear) begin
      last    <= '0;
      holdoff <= '0;
    end else if (accept) begin
      last    <= key;
      holdoff <= CW'(HOLDOFF);
    end else if (holdoff != '0) begin
      holdoff <= holdoff - CW'(1);
    end
  end

endmodule

// File: rtl/registro_teclado_fifo.sv
// rtl/registro_teclado_fifo.sv - keypad keycode FIFO with valid/ready output; TECLADO_REPEAT_FILTER_EN adds repeat filtering
module registro_teclado_fifo
  import teclado_pkg::*;
#(
  parameter int ROW_W   = ROW_W_DEF,
  parameter int COL_W   = COL_W_DEF,
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             clear_i,
  input  logic                             we_i,
  input  logic [ROW_W-1:0]                 cuenta_i,
  input  logic [COL_W-1:0]                 dato_codificador_i,
  output logic [key_width(ROW_W,COL_W)-1:0] dato_teclado_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic                             overflow_o
);

  localparam int KW   = key_width(ROW_W, COL_W);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [KW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            overflow;
  logic [KW-1:0]   key;
  logic            full, empty, pop, push, cand, discard;

  assign key   = {cuenta_i, dato_codificador_i};
  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && ready_i;
  assign cand  = we_i && !discard;
  // A full FIFO still takes a key when a pop frees a slot in the same cycle.
  assign push  = cand && (!full || pop);

`ifdef TECLADO_REPEAT_FILTER_EN
  filtro_repeticion #(
    .KW      (KW),
    .HOLDOFF (HOLDOFF)
  ) u_filtro (
    .clk     (clk_i),
    .rst_n   (reset_ni),
    .clear   (clear_i),
    .key     (key),
    .we      (we_i),
    .accept  (push && !clear_i),
    .discard (discard)
  );
`else
  logic unused_holdoff;
  assign unused_holdoff = (HOLDOFF > 0);
  assign discard        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= key;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CNTW'(1);
      else if (pop && !push) count <= count - CNTW'(1);
      if (cand && full && !pop) overflow <= 1'b1;
    end
  end

  assign dato_teclado_o = mem[rd_ptr];
  assign valid_o        = !empty;
  assign count_o        = count;
  assign full_o         = full;
  assign empty_o        = empty;
  assign overflow_o     = overflow;

endmodule

// File: tb/tb_registro_teclado_fifo.sv
// tb/tb_registro_teclado_fifo.sv - table-driven bench for registro_teclado_fifo (TECLADO_REPEAT_FILTER_EN adds filter sequence)
module tb_registro_teclado_fifo;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       clear_i = 1'b0;
  logic       we_i = 1'b0;
  logic [1:0] cuenta_i = '0;
  logic [1:0] dato_codificador_i = '0;
  logic       ready_i = 1'b0;
  logic [3:0] dato_teclado_o;
  logic       valid_o, full_o, empty_o, overflow_o;
  logic [2:0] count_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  registro_teclado_fifo #(
    .ROW_W(2), .COL_W(2), .DEPTH(4), .HOLDOFF(16)
  ) dut (
    .clk_i              (clk),
    .reset_ni           (reset_ni),
    .clear_i            (clear_i),
    .we_i               (we_i),
    .cuenta_i           (cuenta_i),
    .dato_codificador_i (dato_codificador_i),
    .dato_teclado_o     (dato_teclado_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .count_o            (count_o),
    .full_o             (full_o),
    .empty_o            (empty_o),
    .overflow_o         (overflow_o)
  );

  typedef struct {
    logic       clr;
    logic       we;
    logic [3:0] key;
    logic       rdy;
    logic       v;
    logic [3:0] ek;
    logic [2:0] cnt;
    logic       f;
    logic       e;
    logic       o;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic clr, input logic we, input logic [3:0] key,
                              input logic rdy, input logic v, input logic [3:0] ek,
                              input logic [2:0] cnt, input logic f, input logic e,
                              input logic o);
    vec_t r;
    r.clr = clr; r.we = we; r.key = key; r.rdy = rdy;
    r.v = v; r.ek = ek; r.cnt = cnt; r.f = f; r.e = e; r.o = o;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic we, input logic [3:0] key, input logic rdy);
    clear_i            = clr;
    we_i               = we;
    {cuenta_i, dato_codificador_i} = key;
    ready_i            = rdy;
  endtask

  task automatic step(input logic we, input logic [3:0] key, input logic rdy);
    drive(1'b0, we, key, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"},    valid_o,        0);
    chk({tag, " dato"},     dato_teclado_o, 0);
    chk({tag, " count"},    count_o,        0);
    chk({tag, " full"},     full_o,         0);
    chk({tag, " empty"},    empty_o,        1);
    chk({tag, " overflow"}, overflow_o,     0);
  endtask

  initial begin
    //          clr we key  rdy  v  ek   cnt f  e  o
    tbl[0]  = mk(0, 1, 4'h9, 0, 1, 4'h9, 1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 4'h3, 0, 1, 4'h9, 2, 0, 0, 0);
    tbl[2]  = mk(0, 1, 4'hC, 0, 1, 4'h9, 3, 0, 0, 0);
    tbl[3]  = mk(0, 1, 4'h6, 0, 1, 4'h9, 4, 1, 0, 0);
    tbl[4]  = mk(0, 1, 4'hF, 0, 1, 4'h9, 4, 1, 0, 1);
    tbl[5]  = mk(0, 0, 4'h0, 0, 1, 4'h9, 4, 1, 0, 1);
    tbl[6]  = mk(0, 0, 4'h0, 1, 1, 4'h3, 3, 0, 0, 1);
    tbl[7]  = mk(0, 0, 4'h0, 1, 1, 4'hC, 2, 0, 0, 1);
    tbl[8]  = mk(0, 0, 4'h0, 1, 1, 4'h6, 1, 0, 0, 1);
    tbl[9]  = mk(0, 0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 1);
    tbl[10] = mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 1, 0);
    tbl[11] = mk(0, 1, 4'hA, 1, 1, 4'hA, 1, 0, 0, 0);
    tbl[12] = mk(0, 1, 4'h1, 0, 1, 4'hA, 2, 0, 0, 0);
    tbl[13] = mk(0, 1, 4'h2, 0, 1, 4'hA, 3, 0, 0, 0);
    tbl[14] = mk(0, 1, 4'h3, 0, 1, 4'hA, 4, 1, 0, 0);
    tbl[15] = mk(0, 1, 4'h7, 1, 1, 4'h1, 4, 1, 0, 0);
    tbl[16] = mk(0, 0, 4'h0, 1, 1, 4'h2, 3, 0, 0, 0);
    tbl[17] = mk(0, 0, 4'h0, 1, 1, 4'h3, 2, 0, 0, 0);
    tbl[18] = mk(0, 0, 4'h0, 1, 1, 4'h7, 1, 0, 0, 0);
    tbl[19] = mk(0, 0, 4'h0, 1, 0, 4'h0, 0, 0, 1, 0);
    tbl[20] = mk(0, 1, 4'h4, 0, 1, 4'h4, 1, 0, 0, 0);
    tbl[21] = mk(0, 1, 4'h5, 0, 1, 4'h4, 2, 0, 0, 0);
    tbl[22] = mk(0, 1, 4'h6, 0, 1, 4'h4, 3, 0, 0, 0);
    tbl[23] = mk(1, 1, 4'h8, 0, 0, 4'h0, 0, 0, 1, 0);
    tbl[24] = mk(0, 1, 4'hD, 0, 1, 4'hD, 1, 0, 0, 0);

    reset_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    reset_ni = 1'b1;

    @(posedge clk);
    #1;
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].clr, tbl[i].we, tbl[i].key, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i), valid_o, tbl[i].v);
      if (tbl[i].v) chk($sformatf("v%0d dato", i), dato_teclado_o, tbl[i].ek);
      chk($sformatf("v%0d count", i),    count_o,    tbl[i].cnt);
      chk($sformatf("v%0d full", i),     full_o,     tbl[i].f);
      chk($sformatf("v%0d empty", i),    empty_o,    tbl[i].e);
      chk($sformatf("v%0d overflow", i), overflow_o, tbl[i].o);
    end

    // asynchronous reset in the middle of a drain, away from the clock edge
    step(1'b1, 4'hE, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    chk("pre-reset count", count_o, 3);
    step(1'b0, 4'h0, 1'b1);
    chk("drain count", count_o, 2);
    chk("drain dato", dato_teclado_o, 4'hE);
    #3;
    reset_ni = 1'b0;
    #1;
    chk_reset("async reset");
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    reset_ni = 1'b1;

`ifdef TECLADO_REPEAT_FILTER_EN
    @(posedge clk);
    #1;
    step(1'b1, 4'h5, 1'b0);
    repeat (4) step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    chk("filter repeat held off", count_o, 1);
    chk("filter no overflow", overflow_o, 0);
    repeat (14) step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    chk("filter repeat after holdoff", count_o, 2);
    step(1'b1, 4'hA, 1'b0);
    chk("filter different key", count_o, 3);
    chk("filter head", dato_teclado_o, 4'h5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
